restoring_divider_8bit: RTL and testbench

Sequential unsigned 8-bit restoring divider: the inverse-direction companion to the complex multiplier's add/subtract datapath. It reuses one 9-bit trial subtraction per cycle to produce quotient and remainder over 8 iterations under a start/done handshake. It is used wherever the datapath must normalise or scale results by a runtime divisor.

---
 rtl/restoring_divider_8bit.sv | 109 ++++++++++
 tb/tb_restoring_divider_8bit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned 8-bit restoring divider with a start/done handshake, one trial subtraction per cycle.
// Optional macro DIVIDER_ZERO_CHECK_EN: a zero divisor finishes in one cycle and raises div_by_zero.
module restoring_divider_8bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [7:0] divisor,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       busy,
   output logic       done,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state_q;
   logic [7:0] q_q;
   logic [7:0] d_q;
   logic [8:0] r_q;
   logic [2:0] cnt_q;
   logic [7:0] quotient_q;
   logic [7:0] remainder_q;
   logic       busy_q;
   logic       done_q;
   logic       dbz_q;

   logic [8:0] s_d;
   logic [9:0] sum_d;
   logic       no_borrow_d;
   logic [8:0] r_d;
   logic [7:0] q_d;
   logic       zero_fast_d;

   // Trial subtraction S - D as S + ~D + 1; the carry out is set exactly when S >= D.
   always_comb begin
      s_d         = {r_q[7:0], q_q[7]};
      sum_d       = {1'b0, s_d} + {1'b0, ~{1'b0, d_q}} + 10'd1;
      no_borrow_d = sum_d[9];
      r_d         = no_borrow_d ? sum_d[8:0] : s_d;
      q_d         = {q_q[6:0], no_borrow_d};
   end

`ifdef DIVIDER_ZERO_CHECK_EN
   assign zero_fast_d = (divisor == 8'd0);
`else
   assign zero_fast_d = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         q_q         <= 8'd0;
         d_q         <= 8'd0;
         r_q         <= 9'd0;
         cnt_q       <= 3'd0;
         quotient_q  <= 8'd0;
         remainder_q <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start && zero_fast_d) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  quotient_q  <= 8'hFF;
                  remainder_q <= dividend;
                  dbz_q       <= 1'b1;
               end else if (start) begin
                  state_q <= CALC;
                  busy_q  <= 1'b1;
                  q_q     <= dividend;
                  d_q     <= divisor;
                  r_q     <= 9'd0;
                  cnt_q   <= 3'd0;
               end else begin
                  state_q <= IDLE;
               end
            end
            CALC: begin
               q_q   <= q_d;
               r_q   <= r_d;
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  quotient_q  <= q_d;
                  remainder_q <= r_d[7:0];
                  dbz_q       <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Directed bench for restoring_divider_8bit; honours DIVIDER_ZERO_CHECK_EN when it is defined.
module tb_restoring_divider_8bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int total = 0;
   int bad   = 0;

   restoring_divider_8bit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .quotient   (quotient),
      .remainder  (remainder),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Called at a falling edge; returns at the falling edge of the done cycle (lat = 0 on timeout).
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output int busy_cycles);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      lat         = 0;
      busy_cycles = 0;
      @(negedge clk);
      start    = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         if (busy) busy_cycles++;
         if (done) lat = c;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
      repeat (2) @(negedge clk);
      total++; if (quotient !== 8'd0)  begin bad++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
      total++; if (remainder !== 8'd0) begin bad++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, bc;
      run_op(8'd100, 8'd7, lat, bc);
      total++; if (lat !== 9)          begin bad++; $display("FAIL basic_latency got=%0d exp=9", lat); end
      total++; if (bc !== 8)           begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
      total++; if (quotient !== 8'd14) begin bad++; $display("FAIL basic_quotient got=%0d exp=14", quotient); end
      total++; if (remainder !== 8'd2) begin bad++; $display("FAIL basic_remainder got=%0d exp=2", remainder); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
      @(negedge clk);
      total++; if (done !== 1'b0)      begin bad++; $display("FAIL basic_done_single got=%b exp=0", done); end
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      run_op(8'd255, 8'd1, lat, bc);
      total++; if (quotient !== 8'd255) begin bad++; $display("FAIL b2b_first_quotient got=%0d exp=255", quotient); end
      total++; if (remainder !== 8'd0)  begin bad++; $display("FAIL b2b_first_remainder got=%0d exp=0", remainder); end
      run_op(8'd5, 8'd9, lat, bc);
      total++; if (lat !== 9)           begin bad++; $display("FAIL b2b_latency got=%0d exp=9", lat); end
      total++; if (quotient !== 8'd0)   begin bad++; $display("FAIL b2b_quotient got=%0d exp=0", quotient); end
      total++; if (remainder !== 8'd5)  begin bad++; $display("FAIL b2b_remainder got=%0d exp=5", remainder); end
      @(negedge clk);
      total++; if (done !== 1'b0)       begin bad++; $display("FAIL b2b_done_single got=%b exp=0", done); end
   endtask

   task automatic test_div_zero();
      int lat, bc, exp_lat, exp_bc;
      logic exp_dbz;
`ifdef DIVIDER_ZERO_CHECK_EN
      exp_lat = 1; exp_bc = 0; exp_dbz = 1'b1;
`else
      exp_lat = 9; exp_bc = 8; exp_dbz = 1'b0;
`endif
      run_op(8'd200, 8'd0, lat, bc);
      total++; if (lat !== exp_lat)       begin bad++; $display("FAIL zero_latency got=%0d exp=%0d", lat, exp_lat); end
      total++; if (bc !== exp_bc)         begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=%0d", bc, exp_bc); end
      total++; if (quotient !== 8'hFF)    begin bad++; $display("FAIL zero_quotient got=%0d exp=255", quotient); end
      total++; if (remainder !== 8'd200)  begin bad++; $display("FAIL zero_remainder got=%0d exp=200", remainder); end
      total++; if (div_by_zero !== exp_dbz) begin bad++; $display("FAIL zero_dbz got=%b exp=%b", div_by_zero, exp_dbz); end
      @(negedge clk);
      total++; if (div_by_zero !== exp_dbz) begin bad++; $display("FAIL zero_dbz_hold got=%b exp=%b", div_by_zero, exp_dbz); end
   endtask

   task automatic test_ignore_start();
      int done_cnt = 0;
      int done_at  = 0;
      start = 1'b1; dividend = 8'd77; divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         if (done) begin done_cnt++; if (done_at == 0) done_at = c; end
         if (c == 4) begin
            total++; if (quotient !== 8'hFF) begin bad++; $display("FAIL ignore_quotient_hold got=%0d exp=255", quotient); end
            total++; if (busy !== 1'b1)      begin bad++; $display("FAIL ignore_busy_mid got=%b exp=1", busy); end
            start = 1'b1; dividend = 8'd10; divisor = 8'd2;
         end
         if (c == 5) start = 1'b0;
         if (c == 9) begin
            total++; if (quotient !== 8'd25) begin bad++; $display("FAIL ignore_quotient got=%0d exp=25", quotient); end
            total++; if (remainder !== 8'd2) begin bad++; $display("FAIL ignore_remainder got=%0d exp=2", remainder); end
            total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL ignore_dbz got=%b exp=0", div_by_zero); end
         end
         @(negedge clk);
      end
      total++; if (done_at !== 9)  begin bad++; $display("FAIL ignore_done_at got=%0d exp=9", done_at); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_reset_mid();
      int lat, bc;
      int done_cnt = 0;
      start = 1'b1; dividend = 8'd90; divisor = 8'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      total++; if (quotient !== 8'd0)  begin bad++; $display("FAIL rstmid_quotient got=%0d exp=0", quotient); end
      total++; if (remainder !== 8'd0) begin bad++; $display("FAIL rstmid_remainder got=%0d exp=0", remainder); end
      for (int c = 0; c < 8; c++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      total++; if (done_cnt !== 0)     begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt); end
      run_op(8'd90, 8'd4, lat, bc);
      total++; if (lat !== 9)          begin bad++; $display("FAIL rstmid_rerun_latency got=%0d exp=9", lat); end
      total++; if (quotient !== 8'd22) begin bad++; $display("FAIL rstmid_rerun_quotient got=%0d exp=22", quotient); end
      total++; if (remainder !== 8'd2) begin bad++; $display("FAIL rstmid_rerun_remainder got=%0d exp=2", remainder); end
   endtask

   task automatic test_edges();
      logic [7:0] va [4] = '{8'd0,   8'd255, 8'd254, 8'd128};
      logic [7:0] vb [4] = '{8'd5,   8'd255, 8'd255, 8'd16};
      logic [7:0] vq [4] = '{8'd0,   8'd1,   8'd0,   8'd8};
      logic [7:0] vr [4] = '{8'd0,   8'd0,   8'd254, 8'd0};
      int lat, bc;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], lat, bc);
         total++;
         if (lat !== 9 || quotient !== vq[i] || remainder !== vr[i]) begin
            bad++;
            $display("FAIL edge_%0d_%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=9",
                     va[i], vb[i], quotient, remainder, lat, vq[i], vr[i]);
         end
      end
   endtask

   task automatic test_sweep();
      int lat, bc;
      int eq, er;
      for (int a = 0; a < 256; a += 17) begin
         for (int b = 1; b < 256; b += 6) begin
            run_op(a[7:0], b[7:0], lat, bc);
            eq = a / b;
            er = a % b;
            total++;
            if (lat !== 9 || int'(quotient) != eq || int'(remainder) != er ||
                int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
               bad++;
               $display("FAIL sweep_%0d_%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=9",
                        a, b, quotient, remainder, lat, eq, er);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_edges();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
